// File: rtl/spi_counter.sv
// rtl/spi_counter.sv - bit/clock-tick counter for the SPI block, wraps at MAX_COUNT with a tc pulse
module spi_counter #(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             running
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             running_q, running_d;

   always_comb begin
      count_d   = count_q;
      tc_d      = 1'b0;
      running_d = 1'b0;
      if (!enable) begin
         count_d = '0;
      end else if (!pause) begin
         running_d = 1'b1;
         if (count_q == MAX_Q) begin
            count_d = '0;
            tc_d    = 1'b1;
         end else if (count_q > MAX_Q) begin
            // Recover silently from a corrupted count: restart without framing a transfer.
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         tc_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         tc_q      <= tc_d;
         running_q <= running_d;
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign running = running_q;

endmodule

// File: tb/tb_spi_counter.sv
// tb/tb_spi_counter.sv - scoreboard bench for spi_counter (default and MAX_COUNT=9 instances)
module tb_spi_counter;

   localparam int MAX_A = 255;
   localparam int MAX_B = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] count_a, count_b;
   logic       tc_a, tc_b, running_a, running_b;

   typedef struct {
      int   ca;
      logic ta;
      logic ra;
      int   cb;
      logic tb;
      logic rb;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pushes = 0;
   int   pops   = 0;
   int   ma = 0;
   int   mb = 0;

   spi_counter dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause),
      .count(count_a), .tc(tc_a), .running(running_a)
   );

   spi_counter #(.WIDTH(8), .MAX_COUNT(MAX_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause),
      .count(count_b), .tc(tc_b), .running(running_b)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: counter is modulo (max+1); tc marks the edge that lands on 0 from max.
   function automatic void model(inout int cnt, input int max, output logic t, output logic r);
      t = 1'b0;
      r = 1'b0;
      if (!rst_n || !enable) begin
         cnt = 0;
      end else if (!pause) begin
         r   = 1'b1;
         t   = (cnt == max);
         cnt = (cnt + 1) % (max + 1);
      end
   endfunction

   task automatic drive_push(input logic rst, input logic en, input logic pa);
      exp_t e;
      rst_n  = rst;
      enable = en;
      pause  = pa;
      model(ma, MAX_A, e.ta, e.ra);
      model(mb, MAX_B, e.tb, e.rb);
      e.ca = ma;
      e.cb = mb;
      exp_q.push_back(e);
      pushes++;
   endtask

   task automatic step(input logic rst, input logic en, input logic pa);
      @(negedge clk);
      drive_push(rst, en, pa);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         pops++;
         check("count_a", int'(count_a), e.ca);
         check("tc_a", int'(tc_a), int'(e.ta));
         check("running_a", int'(running_a), int'(e.ra));
         check("count_b", int'(count_b), e.cb);
         check("tc_b", int'(tc_b), int'(e.tb));
         check("running_b", int'(running_b), int'(e.rb));
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      check("reset_count_a", int'(count_a), 0);
      check("reset_tc_a", int'(tc_a), 0);
      check("reset_running_a", int'(running_a), 0);

      repeat (5) step(1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b1, 1'b0);

      repeat (10) step(1'b1, 1'b0, 1'b0);
      repeat (20) step(1'b1, 1'b1, 1'b0);

      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b1, 1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b1, 1'b0);

      step(1'b1, 1'b0, 1'b0);
      repeat (258) step(1'b1, 1'b1, 1'b0);

      step(1'b1, 1'b0, 1'b0);
      repeat (42) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);

      step(1'b1, 1'b0, 1'b0);
      repeat (100) step(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check("pre_async_count_a", int'(count_a), 100);
      rst_n = 1'b0;
      #1;
      check("async_count_a", int'(count_a), 0);
      check("async_count_b", int'(count_b), 0);
      check("async_tc_b", int'(tc_b), 0);
      check("async_running_a", int'(running_a), 0);
      ma = 0;
      mb = 0;
      #1;
      drive_push(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 500; i++) begin
         step(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      check("pops_equal_pushes", pops, pushes);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
